// File: rtl/atsc_intlv_pkg.sv
// Defaults, RAM sizing and FSM states shared by the ATSC interleaver and deinterleaver.
// The RAM holds every branch delay line back to back; branch 0 needs no storage.
package atsc_intlv_pkg;

  localparam int NUM_BRANCH_DEF = 52;
  localparam int DEPTH_STEP_DEF = 4;
  localparam int SEG_LEN_DEF    = 207;

  function automatic int ram_depth(input int nb, input int ds);
    return ds * nb * (nb - 1) / 2;
  endfunction

  localparam int RAM_DEPTH = ram_depth(NUM_BRANCH_DEF, DEPTH_STEP_DEF);
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } intlv_state_t;

endpackage

// File: rtl/atsc_intlv_ram.sv
// Single-port read-first byte RAM; rdata is valid one cycle after an enabled access.
// rdata only changes on enabled cycles, so it can hold an output byte under backpressure.
module atsc_intlv_ram #(
  parameter int DEPTH = 5304,
  parameter int AW    = 13
) (
  input  logic          ce_clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge ce_clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/atsc_interleaver_core.sv
// ATSC convolutional byte interleaver; ATSC_INTLV_STATS_EN adds seg_count/tlast_err counters.
// Latency 1 cycle; in_tready only while the output register is empty or being drained.
module atsc_interleaver_core
  import atsc_intlv_pkg::*;
#(
  parameter int NUM_BRANCH = NUM_BRANCH_DEF,
  parameter int DEPTH_STEP = DEPTH_STEP_DEF,
  parameter int SEG_LEN    = SEG_LEN_DEF
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        clear,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic [31:0] seg_count,
  output logic [15:0] tlast_err
);

  localparam int DEPTH = ram_depth(NUM_BRANCH, DEPTH_STEP);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(NUM_BRANCH);
  localparam int PW    = $clog2(DEPTH_STEP * (NUM_BRANCH - 1));
  localparam int SW    = $clog2(SEG_LEN);

  intlv_state_t  state;
  logic [AW-1:0] init_addr;
  logic [BW-1:0] comm;
  logic [AW-1:0] base;
  logic [PW-1:0] ptr [NUM_BRANCH];
  logic [SW-1:0] in_cnt;
  logic [SW-1:0] out_cnt;
  logic          out_vld_r;
  logic          out_last_r;
  logic          byp_sel;
  logic [7:0]    byp_dat;

  logic          in_hs;
  logic          out_hs;
  logic          comm_last;
  logic [AW-1:0] span;
  logic [AW-1:0] ptr_ext;
  logic          ptr_last;
  logic          in_seg_end;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic          unused_hi;

  assign unused_hi = ^in_tdata[31:8];

  assign in_tready  = (state == ST_RUN) && (!out_vld_r || out_tready);
  assign in_hs      = in_tvalid && in_tready && !clear;
  assign out_hs     = out_vld_r && out_tready;
  assign comm_last  = (comm == BW'(NUM_BRANCH - 1));
  assign span       = AW'(DEPTH_STEP) * AW'(comm);
  assign ptr_ext    = AW'(ptr[comm]);
  assign ptr_last   = (ptr_ext == span - AW'(1));
  assign in_seg_end = (in_cnt == SW'(SEG_LEN - 1));

  // The sweep owns the RAM port during INIT; in RUN only branches b>0 touch it.
  assign ram_en    = (state == ST_INIT) || (in_hs && (comm != '0));
  assign ram_addr  = (state == ST_INIT) ? init_addr : base + ptr_ext;
  assign ram_wdata = (state == ST_INIT) ? 8'h00 : in_tdata[7:0];

  atsc_intlv_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .ce_clk (ce_clk),
    .en     (ram_en),
    .we     (ram_en),
    .addr   (ram_addr),
    .wdata  (ram_wdata),
    .rdata  (ram_rdata)
  );

  assign out_tvalid = out_vld_r;
  assign out_tlast  = out_last_r;
  assign out_tdata  = {24'd0, byp_sel ? byp_dat : ram_rdata};

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state      <= ST_INIT;
      init_addr  <= '0;
      comm       <= '0;
      base       <= '0;
      for (int i = 0; i < NUM_BRANCH; i++) ptr[i] <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_vld_r  <= 1'b0;
      out_last_r <= 1'b0;
      byp_sel    <= 1'b1;
      byp_dat    <= 8'h00;
    end else if (clear) begin
      state      <= ST_INIT;
      init_addr  <= '0;
      comm       <= '0;
      base       <= '0;
      for (int i = 0; i < NUM_BRANCH; i++) ptr[i] <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_vld_r  <= 1'b0;
      out_last_r <= 1'b0;
    end else begin
      if (out_hs) out_vld_r <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_addr == AW'(DEPTH - 1)) begin
            init_addr <= '0;
            state     <= ST_RUN;
          end else begin
            init_addr <= init_addr + AW'(1);
          end
        end
        ST_RUN: begin
          if (in_hs) begin
            out_vld_r  <= 1'b1;
            out_last_r <= (out_cnt == SW'(SEG_LEN - 1));
            out_cnt    <= (out_cnt == SW'(SEG_LEN - 1)) ? '0 : out_cnt + SW'(1);
            byp_sel    <= (comm == '0);
            byp_dat    <= in_tdata[7:0];
            if (comm != '0) ptr[comm] <= ptr_last ? '0 : ptr[comm] + PW'(1);
            // Base of branch b+1 sits DEPTH_STEP*b bytes above branch b.
            comm   <= comm_last ? '0 : comm + BW'(1);
            base   <= comm_last ? '0 : base + span;
            // An early in_tlast realigns the input segment; the commutator keeps going.
            in_cnt <= (in_tlast || in_seg_end) ? '0 : in_cnt + SW'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef ATSC_INTLV_STATS_EN
  logic        tlast_bad;
  logic [31:0] seg_cnt_r;
  logic [15:0] err_cnt_r;

  assign tlast_bad = in_hs && (in_tlast != in_seg_end);

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      seg_cnt_r <= '0;
      err_cnt_r <= '0;
    end else begin
      if (out_hs && out_last_r) seg_cnt_r <= seg_cnt_r + 32'd1;
      if (tlast_bad && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign seg_count = seg_cnt_r;
  assign tlast_err = err_cnt_r;
`else
  assign seg_count = 32'd0;
  assign tlast_err = 16'd0;
`endif

endmodule

// File: tb/tb_atsc_interleaver_core.sv
// Bench for atsc_interleaver_core: scenario table of streams checked against the
// closed-form interleave position k + 208*(k mod 52), plus reset and clear sequences.
module tb_atsc_interleaver_core;

  localparam int NB   = 52;
  localparam int DS   = 4;
  localparam int SEG  = 207;
  localparam int INIT_CYC = DS * NB * (NB - 1) / 2;

`ifdef ATSC_INTLV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tlast = 1'b0;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tlast;
  logic [31:0] seg_count;
  logic [15:0] tlast_err;

  always #5 ce_clk = ~ce_clk;

  atsc_interleaver_core dut (
    .ce_clk     (ce_clk),
    .ce_rst     (ce_rst),
    .clear      (clear),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .seg_count  (seg_count),
    .tlast_err  (tlast_err)
  );

  typedef struct {
    int nbytes;
    int rdy_pct;
    int early;     // stream position carrying an early in_tlast, -1 for none
    bit clr_hs;    // end with clear coincident with an input handshake
    int n_err;     // tlast errors this stream adds
  } scen_t;

  typedef struct {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_seg = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int p);
    int k;
    k = p - DS * NB * (p % NB);
    return (k < 0) ? 8'd0 : 8'(k);
  endfunction

  function automatic bit tlast_at(input int p, input int early);
    if (early < 0 || p < early) return (p % SEG) == SEG - 1;
    if (p == early) return 1'b1;
    return ((p - early - 1) % SEG) == SEG - 1;
  endfunction

  task automatic wait_init(input string nm);
    int cnt;
    bit vld_seen;
    cnt = 0;
    vld_seen = 1'b0;
    while (!in_tready && cnt < INIT_CYC + 200) begin
      @(posedge ce_clk);
      #1;
      cnt++;
      if (out_tvalid) vld_seen = 1'b1;
    end
    chk({nm, " init cycles"}, cnt, INIT_CYC);
    chk({nm, " out_tvalid during init"}, {31'd0, vld_seen}, 32'd0);
  endtask

  task automatic run_stream(input int sidx, input int n, input int rdy_pct, input int early);
    int p;
    int cyc;
    logic [31:0] r;
    exp_t e;
    p = 0;
    cyc = 0;
    exp_q.delete();
    while ((p < n || exp_q.size() > 0) && cyc < n * 4 + 2000) begin
      @(negedge ce_clk);
      cyc++;
      r = $urandom();
      out_tready = ($urandom_range(99) < rdy_pct);
      in_tvalid  = (p < n);
      in_tdata   = {r[31:8], p[7:0]};
      in_tlast   = (p < n) && tlast_at(p, early);
      #1;
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL s%0d spurious output: got %0h, expected none", sidx, out_tdata);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("s%0d out_tdata", sidx), out_tdata, {24'd0, e.dat});
          chk($sformatf("s%0d out_tlast", sidx), {31'd0, out_tlast}, {31'd0, e.last});
        end
      end
      if (in_tvalid && in_tready) begin
        e.dat  = exp_byte(p);
        e.last = ((p % SEG) == SEG - 1);
        exp_q.push_back(e);
        p++;
      end
      @(posedge ce_clk);
      #1;
    end
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    out_tready = 1'b1;
    chk($sformatf("s%0d bytes accepted", sidx), p, n);
    chk($sformatf("s%0d outputs drained", sidx), exp_q.size(), 0);
  endtask

  initial begin
    scen_t tbl [3];
    tbl[0] = '{nbytes: 20001, rdy_pct: 100, early: -1,  clr_hs: 1'b1, n_err: 0};
    tbl[1] = '{nbytes: 12000, rdy_pct: 50,  early: -1,  clr_hs: 1'b0, n_err: 0};
    tbl[2] = '{nbytes: 1500,  rdy_pct: 100, early: 307, clr_hs: 1'b0, n_err: 1};

    repeat (3) @(posedge ce_clk);
    #1;
    chk("reset in_tready", {31'd0, in_tready}, 32'd0);
    chk("reset out_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("reset out_tdata", out_tdata, 32'd0);
    chk("reset out_tlast", {31'd0, out_tlast}, 32'd0);
    chk("reset seg_count", seg_count, 32'd0);
    chk("reset tlast_err", {16'd0, tlast_err}, 32'd0);
    @(negedge ce_clk);
    ce_rst = 1'b0;
    wait_init("reset");

    for (int s = 0; s < 3; s++) begin
      run_stream(s, tbl[s].nbytes, tbl[s].rdy_pct, tbl[s].early);
      if (STATS) begin
        exp_seg += tbl[s].nbytes / SEG;
        exp_err += tbl[s].n_err;
      end
      chk($sformatf("s%0d seg_count", s), seg_count, exp_seg);
      chk($sformatf("s%0d tlast_err", s), {16'd0, tlast_err}, exp_err);

      @(negedge ce_clk);
      clear = 1'b1;
      if (tbl[s].clr_hs) begin
        in_tvalid = 1'b1;
        in_tdata  = 32'h5A5A_00AB;
        #1;
        chk($sformatf("s%0d clear handshake", s), {31'd0, in_tready}, 32'd1);
      end
      @(posedge ce_clk);
      #1;
      clear     = 1'b0;
      in_tvalid = 1'b0;
      chk($sformatf("s%0d out_tvalid after clear", s), {31'd0, out_tvalid}, 32'd0);
      wait_init($sformatf("s%0d clear", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/atsc_interleaver_core.md
ATSC_INTERLEAVER_CORE -- requirements
Module: atsc_interleaver_core

Interface
REQ-001 SHALL have parameter NUM_BRANCH, default 52, meaning commutator branch count.
REQ-002 SHALL have parameter DEPTH_STEP, default 4, meaning delay increment in bytes per branch.
REQ-003 SHALL have parameter SEG_LEN, default 207, meaning bytes per output segment.
REQ-004 SHALL have port ce_clk, input, 1, meaning the one clock; every flop on its rising edge.
REQ-005 SHALL have port ce_rst, input, 1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have port clear, input, 1, meaning a one-cycle pulse that flushes the interleaver.
REQ-007 SHALL have ports in_tdata input 32, in_tvalid input 1, in_tready output 1, in_tlast input 1; in_tdata[7:0] is the byte, [31:8] ignored; in_tlast marks segment end.
REQ-008 SHALL have ports out_tdata output 32, out_tvalid output 1, out_tready input 1, out_tlast output 1; out_tdata = {24'd0, byte}.
REQ-009 SHALL have ports seg_count output 32 and tlast_err output 16, meaning the statistics of REQ-024.

Function
REQ-010 SHALL implement an ATSC convolutional byte interleaver: branch b (0..NUM_BRANCH-1) delays its bytes by b*DEPTH_STEP branch visits; branch 0 passes straight through.
REQ-011 SHALL advance the commutator by one on every input handshake, wrapping NUM_BRANCH-1 -> 0; segment boundaries SHALL NOT reset it.
REQ-012 SHALL hold branch storage in one RAM of DEPTH_STEP*NUM_BRANCH*(NUM_BRANCH-1)/2 bytes (5304 at defaults); branch b base = DEPTH_STEP*b*(b-1)/2, kept as a running register incremented by DEPTH_STEP*b on each commutator step and zeroed on wrap.
REQ-013 SHALL keep a per-branch read/write pointer (0..DEPTH_STEP*b-1), read-before-write at base+ptr, increment it after each visit, and wrap it at DEPTH_STEP*b.
REQ-014 SHALL have FSM states INIT (sweep RAM to 0x00, one address per cycle, in_tready=0) and RUN; reset and clear SHALL enter INIT; INIT SHALL enter RUN after the last address is written.
REQ-015 SHALL drive in_tready = RUN && (!out_tvalid || out_tready).
REQ-016 SHALL assert out_tvalid in the cycle after an input handshake (latency 1) and hold out_tdata/out_tlast stable until the out_tready handshake.
REQ-017 SHALL regenerate out_tlast from an output byte counter, asserted on byte SEG_LEN-1 and wrapping to 0.
REQ-018 SHALL count a tlast error when in_tlast arrives on an input byte other than SEG_LEN-1, or is absent on SEG_LEN-1, then realign the input segment counter to 0 after the in_tlast byte; the commutator is unaffected.
REQ-019 SHALL give clear priority over a simultaneous handshake: the byte is dropped, out_tvalid drops next cycle, and pointers, commutator, base and both segment counters return to 0.
REQ-020 SHALL saturate tlast_err at 16'hFFFF and let seg_count wrap modulo 2^32.

Reset
REQ-021 SHALL reset, asynchronously: out_tvalid=0, out_tdata=0, out_tlast=0, in_tready=0, state=INIT, commutator/base/pointers/counters=0, seg_count=0, tlast_err=0.
REQ-022 SHALL, on reset mid-stream, discard any in-flight byte; the first output after the INIT sweep is 0x00 for every branch b>0 until its delay line fills.
REQ-023 SHALL leave RAM contents uninitialised by reset, relying on the INIT sweep.

Configuration
REQ-024 SHALL compile in the statistics counters only with ATSC_INTLV_STATS_EN: seg_count increments on each out_tlast handshake and tlast_err counts per REQ-018; without the macro, both outputs are tied to 0 and no counter flops exist.

Structure
REQ-025 SHALL place NUM_BRANCH, DEPTH_STEP and SEG_LEN defaults, the RAM depth/address-width constants and the FSM state enum in package atsc_intlv_pkg, shared with the deinterleaver.
REQ-026 SHALL instantiate one sub-module, atsc_intlv_ram: a single-port, read-first, 1-cycle synchronous RAM of 8-bit words.

Verification
REQ-027 SHALL check reset release: in_tready stays 0 for 5304 cycles, then rises; out_tvalid=0 throughout.
REQ-028 SHALL send bytes k mod 256 for k=0..20000 with tlast every 207 and out_tready=1: input byte k (branch k mod 52) appears at output position k+208*(k mod 52); earlier positions are 0x00.
REQ-029 SHALL apply random out_tready backpressure (50%) with the REQ-028 stimulus: the output sequence is identical and no byte is lost or duplicated.
REQ-030 SHALL send in_tlast on byte 100 of a segment: tlast_err=1, input counter realigned, out_tlast still every 207 outputs.
REQ-031 SHALL pulse clear coincident with a handshake mid-stream: the byte is dropped, a 5304-cycle INIT follows, and the output restarts as after reset.
REQ-032 SHALL build without ATSC_INTLV_STATS_EN: seg_count=0 and tlast_err=0 under the REQ-030 stimulus.
